// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: funct3 encodings and
// the access legality check used on the data port.
package mem_pkg;
    localparam int ADDR_W_DEF = 8;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    // Illegal funct3 or an offset that does not match the access size.
    function automatic logic acc_err(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'd3, 3'd6, 3'd7: bad = 1'b1;
            3'd1, 3'd5:       bad = off[0];
            3'd2:             bad = |off;
            default:          bad = 1'b0;
        endcase
        return bad;
    endfunction
endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store enables/replication at grant time and load
// extraction/extension from the registered word at response time.
module lsu_lane
    import mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_ldata
);
    logic [31:0] w_shift;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = 32'h0;
        case (i_funct3)
            F3_SB: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_SH: begin
                o_be    = 4'b0011 << i_st_off;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    assign w_shift = i_word >> {i_ld_off, 3'b000};

    always_comb begin
        o_ldata = 32'h0;
        case (i_ld_funct3)
            F3_LB:   o_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_LH:   o_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_LW:   o_ldata = i_word;
            F3_LBU:  o_ldata = {24'h0, w_shift[7:0]};
            F3_LHU:  o_ldata = {16'h0, w_shift[15:0]};
            default: o_ldata = 32'h0;
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data-first priority with a fetch starvation
// limit, lane steering for stores and one-cycle registered responses.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);
    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] r_starve;
    logic            r_if_rvalid, r_if_err, r_d_rvalid, r_d_err, r_d_st;
    logic [31:0]     r_word;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;

    logic            w_if_win, w_d_win, w_if_err, w_d_err;
    logic [3:0]      w_st_be;
    logic [31:0]     w_st_wdata, w_ldata;

    // Grants are gated by rst_n so nothing reaches the array during reset.
    assign w_if_win = rst_n & if_req & (~d_req | (r_starve == SC_W'(STARVE_MAX)));
    assign w_d_win  = rst_n & d_req & ~w_if_win;
    assign w_if_err = |if_addr[1:0];
    assign w_d_err  = acc_err(d_funct3, d_addr[1:0]);
    assign if_gnt   = w_if_win;
    assign d_gnt    = w_d_win;

    lsu_lane u_lane (
        .i_funct3    (d_funct3),
        .i_st_off    (d_addr[1:0]),
        .i_wdata     (d_wdata),
        .o_be        (w_st_be),
        .o_wdata     (w_st_wdata),
        .i_ld_funct3 (r_f3),
        .i_ld_off    (r_off),
        .i_word      (r_word),
        .o_ldata     (w_ldata)
    );

    always_comb begin
        m_addr  = '0;
        m_we    = 1'b0;
        m_be    = 4'b0000;
        m_wdata = 32'h0;
        if (w_if_win) begin
            m_addr = {if_addr[ADDR_W-1:2], 2'b00};
            m_be   = w_if_err ? 4'b0000 : 4'b1111;
        end else if (w_d_win) begin
            m_addr = {d_addr[ADDR_W-1:2], 2'b00};
            if (!w_d_err) begin
                if (d_we) begin
                    m_we    = 1'b1;
                    m_be    = w_st_be;
                    m_wdata = w_st_wdata;
                end else begin
                    m_be = 4'b1111;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve    <= '0;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_st      <= 1'b0;
            r_word      <= 32'h0;
            r_f3        <= 3'd0;
            r_off       <= 2'd0;
        end else begin
            if (!if_req || w_if_win)
                r_starve <= '0;
            else if (r_starve != SC_W'(STARVE_MAX))
                r_starve <= r_starve + SC_W'(1);
            r_if_rvalid <= w_if_win;
            r_if_err    <= w_if_win & w_if_err;
            r_d_rvalid  <= w_d_win;
            r_d_err     <= w_d_win & w_d_err;
            r_d_st      <= w_d_win & d_we;
            if (w_if_win || w_d_win)
                r_word <= m_rdata;
            if (w_d_win) begin
                r_f3  <= d_funct3;
                r_off <= d_addr[1:0];
            end
        end
    end

    assign if_rvalid = r_if_rvalid;
    assign if_err    = r_if_err;
    assign if_rdata  = (r_if_rvalid & ~r_if_err) ? r_word : 32'h0;
    assign d_rvalid  = r_d_rvalid;
    assign d_err     = r_d_err;
    assign d_rdata   = (r_d_rvalid & ~r_d_err & ~r_d_st) ? w_ldata : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// byte-array reference model of the shared memory and arbitration rules.
module tb_mem_arbiter;
    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [2:0]  d_funct3;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [7:0]  m_addr;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata, m_rdata;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic        do_copy;
    int          n_cmp = 0, n_bad = 0;
    int          lost  = 0;

    logic        g_if_gnt, g_d_gnt, g_m_we, g_if_err, g_d_err, g_d_rvalid;
    logic [3:0]  g_m_be;
    logic [7:0]  g_m_addr;
    logic [31:0] g_d_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    // Memory array the DUT talks to; combinational read, byte-enabled write.
    assign m_rdata = {mem[8'(m_addr + 8'd3)], mem[8'(m_addr + 8'd2)],
                      mem[8'(m_addr + 8'd1)], mem[m_addr]};

    always @(posedge clk) begin
        if (do_copy) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (m_we) begin
            for (int k = 0; k < 4; k++)
                if (m_be[k]) mem[8'(m_addr + 8'(k))] <= m_wdata[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit d_bad(input logic [2:0] f3, input logic [7:0] a);
        if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
        return (int'(a) % nbytes(f3)) != 0;
    endfunction

    function automatic int unsigned word_at(input logic [7:0] a);
        return ref_mem[a] + 256 * ref_mem[8'(a + 1)] + 65536 * ref_mem[8'(a + 2)]
               + 16777216 * ref_mem[8'(a + 3)];
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [7:0] a);
        int unsigned v;
        case (f3)
            3'd0: begin v = ref_mem[a]; if (v >= 128) v += 32'hFFFFFF00; end
            3'd4: v = ref_mem[a];
            3'd1: begin
                v = ref_mem[a] + 256 * ref_mem[8'(a + 1)];
                if (v >= 32768) v += 32'hFFFF0000;
            end
            3'd5: v = ref_mem[a] + 256 * ref_mem[8'(a + 1)];
            default: v = word_at(a);
        endcase
        return v;
    endfunction

    // One cycle: drive at negedge, check grant/memory side, then the response.
    task automatic step(input bit ir, input logic [7:0] ia, input bit dr, input bit dwe,
                        input logic [2:0] f3, input logic [7:0] da, input logic [31:0] wd);
        bit fw, dw, e_ierr, e_derr, e_we;
        logic [7:0] e_addr;
        logic [3:0] e_be;
        logic [31:0] e_wd, e_ird, e_drd;
        int n;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dwe;
        d_funct3 = f3; d_addr = da; d_wdata = wd;
        #1;
        fw = ir && (!dr || lost == SMAX);
        dw = dr && !fw;
        e_addr = 8'h0; e_we = 0; e_be = 4'h0; e_wd = 32'h0;
        e_ierr = 0; e_derr = 0; e_ird = 32'h0; e_drd = 32'h0;
        if (fw) begin
            e_addr = ia & 8'hFC;
            e_ierr = (ia % 4) != 0;
            if (!e_ierr) begin e_be = 4'hF; e_ird = word_at(e_addr); end
        end
        if (dw) begin
            e_addr = da & 8'hFC;
            e_derr = d_bad(f3, da);
            if (!e_derr && dwe) begin
                n = nbytes(f3);
                e_we = 1;
                e_be = 4'(((1 << n) - 1) << (da % 4));
                e_wd = (n == 1) ? wd[7:0] * 32'h01010101 :
                       (n == 2) ? wd[15:0] * 32'h00010001 : wd;
                for (int k = 0; k < n; k++) ref_mem[8'(da + k)] = 8'(wd >> (8 * k));
            end else if (!e_derr) begin
                e_be = 4'hF;
                e_drd = load_val(f3, da);
            end
        end
        lost = (ir && !fw) ? ((lost == SMAX) ? SMAX : lost + 1) : 0;
        g_if_gnt = if_gnt; g_d_gnt = d_gnt; g_m_be = m_be; g_m_addr = m_addr; g_m_we = m_we;
        chk("if_gnt", if_gnt, fw);
        chk("d_gnt", d_gnt, dw);
        chk("m_addr", m_addr, e_addr);
        chk("m_we", m_we, e_we);
        chk("m_be", m_be, e_be);
        if (e_we || (!fw && !dw)) chk("m_wdata", m_wdata, e_wd);
        @(posedge clk); #1;
        g_if_err = if_err; g_d_err = d_err; g_d_rdata = d_rdata; g_d_rvalid = d_rvalid;
        chk("if_rvalid", if_rvalid, fw);
        chk("if_err", if_err, e_ierr);
        chk("if_rdata", if_rdata, e_ird);
        chk("d_rvalid", d_rvalid, dw);
        chk("d_err", d_err, e_derr);
        chk("d_rdata", d_rdata, e_drd);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_if_gnt"}, if_gnt, 0);
        chk({tag, "_d_gnt"}, d_gnt, 0);
        chk({tag, "_m_we"}, m_we, 0);
        chk({tag, "_m_be"}, m_be, 0);
        chk({tag, "_if_rvalid"}, if_rvalid, 0);
        chk({tag, "_d_rvalid"}, d_rvalid, 0);
        chk({tag, "_rdata"}, if_rdata | d_rdata, 0);
        chk({tag, "_err"}, {if_err, d_err}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit p_if, p_d, pwe;
        logic [7:0] pia, pda;
        logic [2:0] pf3;
        logic [31:0] pwd;
        int r;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        do_copy = 1;
        rst_n = 0;
        if_req = 1; if_addr = 8'h00; d_req = 1; d_we = 1; d_funct3 = 3'd2;
        d_addr = 8'h00; d_wdata = 32'hFFFFFFFF;
        #1;
        chk_quiet("reset");
        repeat (2) @(negedge clk);
        do_copy = 0; if_req = 0; d_req = 0;
        @(negedge clk);
        rst_n = 1;

        // Fetch-only stream.
        step(1, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        step(1, 8'h04, 0, 0, 3'd0, 8'h00, 0);
        step(1, 8'h08, 0, 0, 3'd0, 8'h00, 0);
        // Contention: data wins three times, fetch forced on the fourth.
        step(1, 8'h0C, 1, 0, 3'd2, 8'h40, 0); chk("cont1_d", g_d_gnt, 1);
        step(1, 8'h0C, 1, 0, 3'd2, 8'h44, 0);
        step(1, 8'h0C, 1, 0, 3'd2, 8'h48, 0); chk("cont3_d", g_d_gnt, 1);
        step(1, 8'h0C, 1, 0, 3'd2, 8'h4C, 0); chk("starve_win", g_if_gnt, 1);
        step(1, 8'h10, 1, 0, 3'd2, 8'h4C, 0); chk("starve_clr", g_d_gnt, 1);
        // Lane steering and extension.
        step(0, 8'h00, 1, 1, 3'd0, 8'h13, 32'h000000AB);
        chk("sb_be", g_m_be, 4'b1000); chk("sb_addr", g_m_addr, 8'h10);
        step(0, 8'h00, 1, 0, 3'd0, 8'h13, 0); chk("lb", g_d_rdata, 32'hFFFFFFAB);
        step(0, 8'h00, 1, 0, 3'd4, 8'h13, 0); chk("lbu", g_d_rdata, 32'h000000AB);
        step(0, 8'h00, 1, 1, 3'd1, 8'h22, 32'h00008001);
        step(0, 8'h00, 1, 0, 3'd1, 8'h22, 0); chk("lh", g_d_rdata, 32'hFFFF8001);
        // Misaligned and illegal accesses.
        step(0, 8'h00, 1, 0, 3'd2, 8'h06, 0);
        chk("mis_be", g_m_be, 0); chk("mis_err", g_d_err, 1); chk("mis_rdata", g_d_rdata, 0);
        step(1, 8'h02, 0, 0, 3'd0, 8'h00, 0); chk("fetch_mis", g_if_err, 1);
        step(0, 8'h00, 1, 0, 3'd3, 8'h40, 0);
        chk("ill_err", g_d_err, 1); chk("ill_we", g_m_we, 0);

        // Reset asserted during the response cycle of a load.
        if_req = 0; d_req = 1; d_we = 0; d_funct3 = 3'd2; d_addr = 8'h20;
        @(posedge clk); #1;
        rst_n = 0; d_req = 0;
        #1;
        chk_quiet("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1; lost = 0;
        step(0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        step(0, 8'h00, 1, 0, 3'd2, 8'h20, 0);
        chk("post_rst_rv", g_d_rvalid, 1);

        // Random traffic with requests held until granted.
        p_if = 0; p_d = 0; pia = 0; pda = 0; pwe = 0; pf3 = 0; pwd = 0;
        repeat (400) begin
            if (!p_if && $urandom_range(0, 3) != 0) begin
                p_if = 1;
                pia = 8'($urandom);
                if ($urandom_range(0, 7) != 0) pia = pia & 8'hFC;
            end
            if (!p_d && $urandom_range(0, 2) != 0) begin
                p_d = 1;
                pwe = 1'($urandom_range(0, 1));
                r = $urandom_range(0, 11);
                if (pwe) pf3 = (r < 11) ? 3'(r % 3) : 3'd3;
                else if (r < 10) pf3 = (r % 5 < 3) ? 3'(r % 5) : 3'(r % 5 + 1);
                else pf3 = (r == 10) ? 3'd3 : 3'd6 + 3'($urandom_range(0, 1));
                pda = 8'h40 | 8'($urandom_range(0, 31));
                if ($urandom_range(0, 5) != 0) pda = pda & ((nbytes(pf3) == 4) ? 8'hFC :
                                                         (nbytes(pf3) == 2) ? 8'hFE : 8'hFF);
                pwd = $urandom;
            end
            step(p_if, pia, p_d, pwe, pf3, pda, pwd);
            if (g_if_gnt) p_if = 0;
            if (g_d_gnt) p_d = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
